// File: rtl/fetch_unit.sv
// Fetch unit: a five-state sequencer that fetches, decodes and executes one instruction at a time.
// Define FETCH_PERF_CNT_EN to add the 16-bit saturating retired-instruction counter output retired_cnt.
module fetch_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] imem_addr,
  output logic       imem_rd_en,
  input  logic [8:0] imem_rdata,
  input  logic       imem_valid,
  output logic [8:0] inst,
  output logic       decoder_en,
  input  logic       exec_done,
  input  logic       branch,
  input  logic [7:0] branch_target,
  input  logic       branchi,
  input  logic [5:0] immediate,
  input  logic       done,
  output logic [7:0] pc,
  output logic       halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [8:0] inst_q, inst_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= 8'h00;
      inst_q  <= 9'h000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        if (imem_valid) begin
          inst_d  = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (exec_done) begin
          if (done) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
            if (branch)       pc_d = branch_target;
            else if (branchi) pc_d = pc_q + {{2{immediate[5]}}, immediate};
            else              pc_d = pc_q + 8'd1;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_rd_en = (state_q == FETCH);
    decoder_en = (state_q == DECODE);
    halted     = (state_q == HALT);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;

  // Counts every completed instruction, including the one that halts, and sticks at the top.
  always_comb begin
    retired_d = retired_q;
    if (state_q == EXEC && exec_done && retired_q != 16'hFFFF)
      retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= 16'h0000;
    else        retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

endmodule
